// File: rtl/bp_btb_2bit_if.sv
// Fetch-lookup, EX-resolution and statistics signals of the branch predictor.
// The master side (PC-select / pipeline) drives PCs and resolution data; the
// slave side (the predictor) returns the prediction and the misprediction class.
interface bp_btb_2bit_if #(
  parameter int STAT_W = 32
);
  logic [31:0]       pc_i;
  logic              hit_o;
  logic              pred_taken_o;
  logic [31:0]       predicted_pc_o;
  logic              ex_valid_i;
  logic [31:0]       ex_pc_i;
  logic              ex_is_branch_i;
  logic              ex_is_jump_i;
  logic              ex_taken_i;
  logic [31:0]       ex_target_i;
  logic              ex_pred_taken_i;
  logic [31:0]       ex_pred_pc_i;
  logic [1:0]        wrong_predicted_o;
  logic [31:0]       redirect_pc_o;
  logic              stats_clr_i;
  logic [STAT_W-1:0] branch_cnt_o;
  logic [STAT_W-1:0] mispred_cnt_o;

  modport master (
    output pc_i, ex_valid_i, ex_pc_i, ex_is_branch_i, ex_is_jump_i, ex_taken_i,
    output ex_target_i, ex_pred_taken_i, ex_pred_pc_i, stats_clr_i,
    input  hit_o, pred_taken_o, predicted_pc_o, wrong_predicted_o, redirect_pc_o,
    input  branch_cnt_o, mispred_cnt_o
  );

  modport slave (
    input  pc_i, ex_valid_i, ex_pc_i, ex_is_branch_i, ex_is_jump_i, ex_taken_i,
    input  ex_target_i, ex_pred_taken_i, ex_pred_pc_i, stats_clr_i,
    output hit_o, pred_taken_o, predicted_pc_o, wrong_predicted_o, redirect_pc_o,
    output branch_cnt_o, mispred_cnt_o
  );
endinterface

// File: rtl/bp_btb_2bit.sv
// Direct-mapped BTB with per-entry 2-bit saturating direction counters.
// Fetch lookup is combinational on pc_i; EX resolution classifies the
// prediction combinationally and trains the table at the next posedge.
// A same-cycle fetch/EX index collision sees the pre-update entry.
module bp_btb_2bit #(
  parameter int ENTRIES = 32,
  parameter int TAG_W   = 25,
  parameter int STAT_W  = 32
) (
  input logic         clk_i,
  input logic         rst_i,
  bp_btb_2bit_if.slave bus
);
  localparam int IDX_W = $clog2(ENTRIES);

  logic              valid_r  [ENTRIES];
  logic [TAG_W-1:0]  tag_r    [ENTRIES];
  logic [31:0]       target_r [ENTRIES];
  logic [1:0]        cnt_r    [ENTRIES];
  logic [STAT_W-1:0] branch_cnt_r;
  logic [STAT_W-1:0] mispred_cnt_r;

  logic [IDX_W-1:0]  fetch_idx_s;
  logic [TAG_W-1:0]  fetch_tag_s;
  logic [IDX_W-1:0]  ex_idx_s;
  logic [TAG_W-1:0]  ex_tag_s;
  logic              ex_hit_s;
  logic              ctl_s;
  logic              tk_s;
  logic              stale_s;
  logic [1:0]        wrong_s;
  logic              unused_s;

  assign fetch_idx_s = bus.pc_i[2 +: IDX_W];
  assign fetch_tag_s = bus.pc_i[2+IDX_W +: TAG_W];
  assign ex_idx_s    = bus.ex_pc_i[2 +: IDX_W];
  assign ex_tag_s    = bus.ex_pc_i[2+IDX_W +: TAG_W];
  assign unused_s    = ^{bus.pc_i[1:0], bus.ex_pc_i[1:0]};

  // Fetch lookup; the target is driven even on a miss and gated by pred_taken downstream.
  always_comb begin
    bus.hit_o          = 1'b0;
    bus.pred_taken_o   = 1'b0;
    bus.predicted_pc_o = target_r[fetch_idx_s];
    if (valid_r[fetch_idx_s] && (tag_r[fetch_idx_s] == fetch_tag_s)) begin
      bus.hit_o        = 1'b1;
      bus.pred_taken_o = cnt_r[fetch_idx_s][1];
    end else begin
      bus.hit_o        = 1'b0;
      bus.pred_taken_o = 1'b0;
    end
  end

  // Resolution: classify the prediction and pick the corrected next PC.
  always_comb begin
    ctl_s    = bus.ex_valid_i & (bus.ex_is_branch_i | bus.ex_is_jump_i);
    tk_s     = bus.ex_is_jump_i | bus.ex_taken_i;
    stale_s  = bus.ex_valid_i & ~bus.ex_is_branch_i & ~bus.ex_is_jump_i & bus.ex_pred_taken_i;
    ex_hit_s = valid_r[ex_idx_s] & (tag_r[ex_idx_s] == ex_tag_s);
    wrong_s  = 2'b00;
    if ((ctl_s & ~tk_s & bus.ex_pred_taken_i) | stale_s) begin
      wrong_s = 2'b01;
    end else if (ctl_s & tk_s & ~bus.ex_pred_taken_i) begin
      wrong_s = 2'b10;
    end else if (ctl_s & tk_s & bus.ex_pred_taken_i & (bus.ex_target_i != bus.ex_pred_pc_i)) begin
      wrong_s = 2'b11;
    end else begin
      wrong_s = 2'b00;
    end
    if (ctl_s & tk_s) begin
      bus.redirect_pc_o = bus.ex_target_i;
    end else begin
      bus.redirect_pc_o = bus.ex_pc_i + 32'd4;
    end
    bus.wrong_predicted_o = wrong_s;
  end

  // Table training: counter/target update on hit, allocate on taken miss, invalidate stale entries.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_r[i]  <= 1'b0;
        tag_r[i]    <= {TAG_W{1'b0}};
        target_r[i] <= 32'd0;
        cnt_r[i]    <= 2'b00;
      end
    end else if (ctl_s && ex_hit_s) begin
      if (tk_s) begin
        target_r[ex_idx_s] <= bus.ex_target_i;
        if (cnt_r[ex_idx_s] != 2'b11) begin
          cnt_r[ex_idx_s] <= cnt_r[ex_idx_s] + 2'b01;
        end
      end else if (cnt_r[ex_idx_s] != 2'b00) begin
        cnt_r[ex_idx_s] <= cnt_r[ex_idx_s] - 2'b01;
      end
    end else if (ctl_s && tk_s) begin
      valid_r[ex_idx_s]  <= 1'b1;
      tag_r[ex_idx_s]    <= ex_tag_s;
      target_r[ex_idx_s] <= bus.ex_target_i;
      cnt_r[ex_idx_s]    <= bus.ex_is_jump_i ? 2'b11 : 2'b10;
    end else if (stale_s) begin
      valid_r[ex_idx_s] <= 1'b0;
    end
  end

  // Saturating performance counters; a clear wins over a same-cycle increment.
  always_ff @(posedge clk_i) begin
    if (rst_i || bus.stats_clr_i) begin
      branch_cnt_r  <= {STAT_W{1'b0}};
      mispred_cnt_r <= {STAT_W{1'b0}};
    end else begin
      if (ctl_s && (branch_cnt_r != {STAT_W{1'b1}})) begin
        branch_cnt_r <= branch_cnt_r + {{(STAT_W-1){1'b0}}, 1'b1};
      end
      if ((wrong_s != 2'b00) && (mispred_cnt_r != {STAT_W{1'b1}})) begin
        mispred_cnt_r <= mispred_cnt_r + {{(STAT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign bus.branch_cnt_o  = branch_cnt_r;
  assign bus.mispred_cnt_o = mispred_cnt_r;
endmodule

// File: doc/bp_btb_2bit.md
# bp_btb_2bit

Parametrised branch predictor for the RV32I pipeline. Combines a direct-mapped branch target buffer with per-entry 2-bit saturating direction counters and performance counters. Fetch performs a same-cycle lookup on the current PC. EX reports each resolved control-flow instruction, and the block returns a misprediction classification and the corrected redirect PC to the PC-select logic.

## Interface
Parameters:
- ENTRIES, 32: BTB entries; power of two, ≥2. IDX_W = log2(ENTRIES).
- TAG_W, 25: tag bits, taken from pc[2+IDX_W +: TAG_W]. Requires 2+IDX_W+TAG_W ≤ 32.
- STAT_W, 32: width of the performance counters.

Ports:
- clk_i  in  1  clock; single clock domain.
- rst_i  in  1  reset; synchronous, active-high.
- pc_i  in  32  fetch PC.
- hit_o  out  1  valid entry whose tag matches pc_i.
- pred_taken_o  out  1  hit_o & counter[1].
- predicted_pc_o  out  32  stored target of the indexed entry.
- ex_valid_i  in  1  EX-stage instruction is valid (not a bubble or flush).
- ex_pc_i  in  32  EX-stage PC.
- ex_is_branch_i  in  1  conditional B-type instruction.
- ex_is_jump_i  in  1  JAL or JALR.
- ex_taken_i  in  1  resolved direction; ignored when ex_is_jump_i = 1, which is always taken.
- ex_target_i  in  32  resolved target (ALU output).
- ex_pred_taken_i  in  1  pred_taken_o pipelined alongside the instruction.
- ex_pred_pc_i  in  32  predicted_pc_o pipelined alongside the instruction.
- wrong_predicted_o  out  2  misprediction class, defined under Operation.
- redirect_pc_o  out  32  correct next PC.
- stats_clr_i  in  1  clears both performance counters.
- branch_cnt_o  out  STAT_W  number of resolved control-flow instructions.
- mispred_cnt_o  out  STAT_W  number of mispredictions.

## Operation
- Entry fields: {valid, tag[TAG_W], target[32], cnt[2]}. Index = pc[2 +: IDX_W].
- Lookup is purely combinational.
  - hit_o = valid & (tag == pc_i tag field).
  - predicted_pc_o is driven from the indexed entry even on a miss; consumers must gate it with pred_taken_o.
- Resolution:
  - ctl = ex_valid_i & (ex_is_branch_i | ex_is_jump_i).
  - tk = ex_is_jump_i | ex_taken_i.
- wrong_predicted_o is evaluated in this order:
  - 2'b01: (ctl & ~tk & ex_pred_taken_i), or (ex_valid_i & ~ex_is_branch_i & ~ex_is_jump_i & ex_pred_taken_i), i.e. a stale entry on a non-control instruction.
  - 2'b10: ctl & tk & ~ex_pred_taken_i.
  - 2'b11: ctl & tk & ex_pred_taken_i & (ex_target_i != ex_pred_pc_i).
  - 2'b00: all other cases, including ex_valid_i = 0.
- redirect_pc_o = tk & ctl ? ex_target_i : ex_pc_i + 4. It is meaningful only when wrong_predicted_o != 0.
- BTB update, applied at posedge, indexed by ex_pc_i. EX hit means the entry is valid and its tag matches ex_pc_i.
  - ctl & EX hit: cnt increments when tk (saturating at 11) and decrements otherwise (saturating at 00). When tk, target is overwritten with ex_target_i. valid stays 1 even at cnt = 00.
  - ctl & EX miss & tk: allocate, overwriting any previous occupant. Write valid = 1, the tag, target = ex_target_i, and cnt = 2'b11 for a jump or 2'b10 for a branch.
  - ctl & EX miss & ~tk: no write.
  - Stale case (class 01 on a non-control instruction): clear valid of the indexed entry.
  - ex_valid_i = 0: no write.
- Performance counters:
  - branch_cnt_o increments on ctl.
  - mispred_cnt_o increments on wrong_predicted_o != 0.
  - Both saturate at all-ones.
  - stats_clr_i has priority over an increment in the same cycle; the counter result is 0.

## Timing
- Reset, with rst_i sampled high at posedge:
  - All valid bits = 0, all cnt = 00, all targets = 0.
  - branch_cnt_o = mispred_cnt_o = 0.
  - Consequently hit_o = 0, pred_taken_o = 0, and predicted_pc_o = 0 after reset.
  - wrong_predicted_o and redirect_pc_o follow the inputs combinationally.
- Reset asserted mid-operation overrides any update in that cycle.
- Lookup latency is 0 cycles. An update becomes visible to lookup in the cycle after the posedge that writes it; there is no write-through bypass.
- When the fetch and EX indices collide in the same cycle, fetch sees the pre-update entry.
- wrong_predicted_o and redirect_pc_o are combinational from the EX inputs, with 0-cycle latency.
- The counters update at the posedge following the qualifying cycle.

## Test plan
- Reset, then lookup of any pc_i → hit_o = 0, pred_taken_o = 0, predicted_pc_o = 0, both counters = 0.
- Taken BEQ at 0x100 → 0x80, with ex_pred_taken_i = 0:
  - Same cycle: wrong_predicted_o = 10, redirect_pc_o = 0x80.
  - Next cycle, pc_i = 0x100: hit_o = 1, pred_taken_o = 1, predicted_pc_o = 0x80.
  - mispred_cnt_o = 1.
- Same branch resolved not-taken twice while predicted taken:
  - Both resolutions: class 01, redirect_pc_o = 0x104.
  - After the first: cnt 10→01, pred_taken_o = 0, hit_o stays 1.
  - After the second: cnt = 00.
  - Then 3 taken resolutions: cnt saturates at 11.
- JALR at 0x200 predicted with target 0x300, resolving to 0x340 → class 11, redirect_pc_o = 0x340. Next lookup of 0x200 → predicted_pc_o = 0x340.
- Aliasing, ENTRIES = 32: 0x1000 is allocated, then a taken branch at 0x1080 (same index, different tag) resolves. Afterwards 0x1000 misses and 0x1080 hits.
- Non-branch at 0x100 with ex_pred_taken_i = 1 → class 01, redirect_pc_o = 0x104, and the entry is invalidated. Same cycle as a counter increment with stats_clr_i = 1 → counters read 0 afterwards.
